// File: rtl/scsi_port_pkg.sv
// Shared types and constants for the SCSI port strobe sequencer.
// Optional IORDY wait-state input is enabled by defining PORT_IORDY_EN.
package scsi_port_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SEL_CSS  = 2'd0,
        SEL_CSX0 = 2'd1,
        SEL_CSX1 = 2'd2,
        SEL_NONE = 2'd3
    } sel_e;

    localparam logic [15:0] RD_NONE = 16'hFFFF;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scsi_port_seq.sv
// Timed strobe sequencer: drives chip selects, _IOR/_IOW and P_DATA with programmable
// setup/strobe/hold/recovery timing. Define PORT_IORDY_EN to add the IORDY wait input.
module scsi_port_seq
    import scsi_port_pkg::*;
#(
    parameter int unsigned SETUP_CYC    = 1,
    parameter int unsigned STROBE_CYC   = 3,
    parameter int unsigned HOLD_CYC     = 1,
    parameter int unsigned RECOVERY_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        rnw_i,
    input  logic [1:0]  sel_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] rdata_o,
    output logic        ack_o,
    output logic        busy_o,
    input  logic [15:0] p_data_in_i,
    output logic [15:0] p_data_out_o,
    output logic        p_data_oe_o,
    output logic        css_n_o,
    output logic        csx0_n_o,
    output logic        csx1_n_o,
    output logic        ior_n_o,
`ifdef PORT_IORDY_EN
    output logic        iow_n_o,
    input  logic        iordy_i
`else
    output logic        iow_n_o
`endif
);

    localparam int unsigned MAX_CYC = max_u(max_u(SETUP_CYC, STROBE_CYC),
                                            max_u(HOLD_CYC, RECOVERY_CYC));
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVERY_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             rnw_q, rnw_d;
    sel_e             sel_q, sel_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [15:0]      rdata_q, rdata_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             oe_q, oe_d;
    logic             css_n_q, css_n_d;
    logic             csx0_n_q, csx0_n_d;
    logic             csx1_n_q, csx1_n_d;
    logic             ior_n_q, ior_n_d;
    logic             iow_n_q, iow_n_d;
    logic             iordy_ok;
    logic             in_phase;

`ifdef PORT_IORDY_EN
    assign iordy_ok = iordy_i;
`else
    assign iordy_ok = 1'b1;
`endif

    // Next state, captured request fields and registered-output next values
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rnw_d    = rnw_q;
        sel_d    = sel_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        armed_d  = armed_q;
        in_phase = 1'b0;

        // A REQ still high after the ACK cycle disarms until REQ is seen low
        if (!req_i) begin
            armed_d = 1'b1;
        end else if (ack_q) begin
            armed_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (req_i && armed_q) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                    rnw_d   = rnw_i;
                    sel_d   = sel_e'(sel_i);
                    wdata_d = wdata_i;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (iordy_ok) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                    if (rnw_q) begin
                        rdata_d = (sel_q == SEL_NONE) ? RD_NONE : p_data_in_i;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = RECOVER;
                    cnt_d   = RECOVER_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RECOVER: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        in_phase = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        css_n_d  = !(in_phase && (sel_d == SEL_CSS));
        csx0_n_d = !(in_phase && (sel_d == SEL_CSX0));
        csx1_n_d = !(in_phase && (sel_d == SEL_CSX1));
        ior_n_d  = !((state_d == STROBE) && rnw_d && (sel_d != SEL_NONE));
        iow_n_d  = !((state_d == STROBE) && !rnw_d && (sel_d != SEL_NONE));
        oe_d     = in_phase && !rnw_d;
        ack_d    = (state_q == HOLD) && (state_d == RECOVER);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            armed_q  <= 1'b1;
            rnw_q    <= 1'b1;
            sel_q    <= SEL_NONE;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            oe_q     <= 1'b0;
            css_n_q  <= 1'b1;
            csx0_n_q <= 1'b1;
            csx1_n_q <= 1'b1;
            ior_n_q  <= 1'b1;
            iow_n_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            rnw_q    <= rnw_d;
            sel_q    <= sel_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            oe_q     <= oe_d;
            css_n_q  <= css_n_d;
            csx0_n_q <= csx0_n_d;
            csx1_n_q <= csx1_n_d;
            ior_n_q  <= ior_n_d;
            iow_n_q  <= iow_n_d;
        end
    end

    assign rdata_o      = rdata_q;
    assign ack_o        = ack_q;
    assign busy_o       = busy_q;
    assign p_data_out_o = wdata_q;
    assign p_data_oe_o  = oe_q;
    assign css_n_o      = css_n_q;
    assign csx0_n_o     = csx0_n_q;
    assign csx1_n_o     = csx1_n_q;
    assign ior_n_o      = ior_n_q;
    assign iow_n_o      = iow_n_q;

endmodule
